// File: rtl/parity_serializer.sv
// parity_serializer: LSB-first serializer that appends one parity bit per word.
// Optional macro PARITY_SERIALIZER_ERR_INJ_EN adds err_inj to invert one word's parity bit.
module parity_serializer #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic             ready,
    output logic             tx,
    output logic             tx_valid,
    output logic             tx_last
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            par_q, par_d;
    logic            par_out;
    logic            xfer;

    assign xfer = valid && ready;

`ifdef PARITY_SERIALIZER_ERR_INJ_EN
    logic inj_q, inj_d;
    assign inj_d   = xfer ? err_inj : inj_q;
    assign par_out = par_q ^ inj_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inj_q <= 1'b0;
        else     inj_q <= inj_d;
    end
`else
    assign par_out = par_q;
`endif

    // Outputs come only from registered state so data/valid never reach them.
    always_comb begin
        ready    = state_q != DATA;
        tx_valid = state_q != IDLE;
        tx_last  = state_q == PARITY;
        tx       = state_q == DATA ? shift_q[0] : state_q == PARITY ? par_out : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (xfer) begin
            state_d = DATA;
            shift_d = data;
            cnt_d   = '0;
            par_d   = (ODD != 0);
        end else if (state_q == DATA) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            par_d   = par_q ^ shift_q[0];
            state_d = cnt_q == CW'(WIDTH - 1) ? PARITY : DATA;
        end else if (state_q == PARITY) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end
endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: directed checks of parity_serializer for WIDTH=8 even/odd and WIDTH=1.
module tb_parity_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic [0:0] data_c = '0;
    logic valid_a = 0, valid_b = 0, valid_c = 0;
    logic ready_a, tx_a, tx_valid_a, tx_last_a;
    logic ready_b, tx_b, tx_valid_b, tx_last_b;
    logic ready_c, tx_c, tx_valid_c, tx_last_c;
    int tests = 0;
    int fails = 0;
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
    logic err_inj = 0, err_b = 0, err_c = 0;
`endif

    always #5 clk = ~clk;

    parity_serializer #(.WIDTH(8), .ODD(0)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .valid(valid_a),
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .ready(ready_a), .tx(tx_a), .tx_valid(tx_valid_a), .tx_last(tx_last_a));

    parity_serializer #(.WIDTH(8), .ODD(1)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .valid(valid_b),
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
        .err_inj(err_b),
`endif
        .ready(ready_b), .tx(tx_b), .tx_valid(tx_valid_b), .tx_last(tx_last_b));

    parity_serializer #(.WIDTH(1), .ODD(0)) dut_c (
        .clk(clk), .rst(rst), .data(data_c), .valid(valid_c),
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
        .err_inj(err_c),
`endif
        .ready(ready_c), .tx(tx_c), .tx_valid(tx_valid_c), .tx_last(tx_last_c));

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] w, input logic p);
        @(negedge clk);
        data_a  = w;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("data_valid[%0d]", i), tx_valid_a, 1'b1);
            chk($sformatf("data_bit[%0d]", i), tx_a, w[i]);
            chk($sformatf("data_last[%0d]", i), tx_last_a, 1'b0);
            chk($sformatf("data_ready[%0d]", i), ready_a, 1'b0);
            @(posedge clk); #1;
        end
        chk("par_valid", tx_valid_a, 1'b1);
        chk("par_last", tx_last_a, 1'b1);
        chk("par_bit", tx_a, p);
        chk("par_ready", ready_a, 1'b1);
        @(posedge clk); #1;
        chk("idle_valid", tx_valid_a, 1'b0);
        chk("idle_ready", ready_a, 1'b1);
    endtask

    initial begin
        #1;
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_valid", tx_valid_a, 1'b0);
        chk("rst_tx", tx_a, 1'b0);
        chk("rst_last", tx_last_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_a(8'hA5, 1'b0);
        send_a(8'h07, 1'b1);
        // Back-to-back 01 then FF with valid held high.
        @(negedge clk);
        data_a  = 8'h01;
        valid_a = 1'b1;
        #1;
        chk("b2b_ready0", ready_a, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_valid[%0d]", c), tx_valid_a, 1'b1);
            chk($sformatf("b2b_ready[%0d]", c), ready_a, c == 9 || c == 18);
            chk($sformatf("b2b_last[%0d]", c), tx_last_a, c == 9 || c == 18);
            if (c == 9) begin
                chk("b2b_par0", tx_a, 1'b1);
                data_a = 8'hFF;
            end
            if (c == 18) begin
                chk("b2b_par1", tx_a, 1'b0);
                valid_a = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("b2b_end_valid", tx_valid_a, 1'b0);
        // Reset during bit 3 of 3C, then a clean 80.
        @(negedge clk);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_bit3", tx_a, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", tx_valid_a, 1'b0);
        chk("abort_ready", ready_a, 1'b1);
        chk("abort_last", tx_last_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_a(8'h80, 1'b1);
`ifdef PARITY_SERIALIZER_ERR_INJ_EN
        err_inj = 1'b1;
        send_a(8'hA5, 1'b1);
        err_inj = 1'b0;
        send_a(8'hA5, 1'b0);
`endif
        // Odd parity of an all-zero word.
        @(negedge clk);
        data_b  = 8'h00;
        valid_b = 1'b1;
        @(posedge clk); #1;
        valid_b = 1'b0;
        chk("odd_valid", tx_valid_b, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("odd_last", tx_last_b, 1'b1);
        chk("odd_par", tx_b, 1'b1);
        // WIDTH=1: one data cycle then one parity cycle.
        @(negedge clk);
        data_c  = 1'b1;
        valid_c = 1'b1;
        @(posedge clk); #1;
        valid_c = 1'b0;
        chk("w1_valid0", tx_valid_c, 1'b1);
        chk("w1_bit", tx_c, 1'b1);
        chk("w1_last0", tx_last_c, 1'b0);
        @(posedge clk); #1;
        chk("w1_valid1", tx_valid_c, 1'b1);
        chk("w1_par", tx_c, 1'b1);
        chk("w1_last1", tx_last_c, 1'b1);
        @(posedge clk); #1;
        chk("w1_valid2", tx_valid_c, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
